lsu_rmw_ctrl: RTL and testbench
===============================

Name: lsu_rmw_ctrl

Overview:
- Load/store control sits between the EX/MEM pipeline register and the byte-addressed data memory.
- The memory always reads and writes the 4 bytes at address..address+3. This block turns RV32 LB/LH/LW/LBU/LHU/SB/SH/SW into memory transactions.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Provides a valid/ready request handshake, so the pipeline stalls while the block is busy.

Parameters:
- MEM_BYTES, 128, memory size in bytes; every access must satisfy addr+4 <= MEM_BYTES.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present from EX/MEM.
- req_ready  out  1  block can accept; the pipeline stalls while it is low.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_funct3  in  3  RV32 funct3 access type.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2).
- mem_address  out  32  to memory address.
- mem_writeData  out  32  to memory write data.
- mem_memRead  out  1  memory read enable.
- mem_memWrite  out  1  memory write enable.
- mem_rdata  in  32  combinational read data from memory.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  request rejected (qualified by rsp_valid).
- rsp_data  out  32  extended load data; 0 for stores and errors.

Behaviour:
- States and memory strobes:
  - IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
  - req_ready = 1 only in IDLE.
  - mem_memRead = 1 only in LOAD and RMW_RD.
  - mem_memWrite = 1 only in WRITE and RMW_WR.
  - Both strobes are decoded combinationally from state.
- Accept rule: the request is accepted on the edge where req_valid && req_ready. Address, funct3, wdata and kind are latched; mem_address drives the latched address.
- Error check at accept:
  - err if req_load == req_store, or funct3 is not legal for the kind (loads 0,1,2,4,5; stores 0,1,2), or {1'b0,addr}+4 > MEM_BYTES (33-bit compare, no wrap).
  - An error goes IDLE->RESP with rsp_err=1 and issues no memory strobe.
- Transitions:
  - Load: IDLE->LOAD->RESP->IDLE. In LOAD, rsp_data is registered from mem_rdata:
    - LB: sign-extend [7:0].
    - LBU: zero-extend [7:0].
    - LH: sign-extend [15:0].
    - LHU: zero-extend [15:0].
    - LW: full word.
  - SW: IDLE->WRITE->RESP->IDLE; mem_writeData = wdata.
  - SB/SH: IDLE->RMW_RD->RMW_WR->RESP->IDLE.
    - In RMW_RD, the merge register captures mem_rdata.
    - In RMW_WR, mem_writeData is {old[31:8],wdata[7:0]} for SB and {old[31:16],wdata[15:0]} for SH.
- Response: RESP drives rsp_valid=1 for exactly one cycle. rsp_err and rsp_data are held until the next RESP.
- Latency, accept edge to rsp_valid high:
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- A new request can be accepted in the cycle after RESP.
- Byte order is little-endian: the byte at addr is bits [7:0].
- Misaligned addresses are performed as-is unless the optional feature below is enabled.
- Reset (reset low, asynchronous) immediately sets:
  - state = IDLE;
  - req_ready = 1;
  - mem_memRead = mem_memWrite = 0;
  - rsp_valid = rsp_err = 0;
  - rsp_data, mem_address and mem_writeData = 0.
- Reset asserted mid-RMW aborts the write; memory is never written with a partial merge.
- Requests are ignored while reset is low.
- Inputs other than req_valid are don't-care when no request is accepted.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: halfword accesses with addr[0]!=0 and word accesses with addr[1:0]!=0 are errors. The path is IDLE->RESP with rsp_err=1 and no memory strobe.
- Undefined: alignment is not checked; the access completes normally if in range.

Test Plan:
- Reset: reset low mid-RMW_RD -> mem_memWrite=0, state IDLE, rsp_valid=0; after release, the next request is accepted immediately.
- SW then LW: SW addr 8, wdata 0xDEADBEEF -> one memWrite cycle, rsp_valid 2 cycles after accept. LW addr 8 -> rsp_data 0xDEADBEEF, rsp_err 0.
- SB RMW: memory word at 8 = 0x11223344. SB addr 8, wdata 0xFFFFFFAB -> memRead cycle, then memWrite with 0x112233AB; later LW 8 returns 0x112233AB.
- Extension: word at 12 = 0x000080F0.
  - LB 12 -> 0xFFFFFFF0.
  - LBU 12 -> 0x000000F0.
  - LH 12 -> 0xFFFF80F0.
  - LHU 12 -> 0x000080F0.
- Boundary/errors with MEM_BYTES=128:
  - LW 124 -> ok.
  - LW 125 -> rsp_err=1 with no strobe.
  - addr 0xFFFFFFFE -> err (no wrap).
  - store funct3=4 -> err.
  - req_load=req_store=1 -> err, rsp_valid 1 cycle after accept.
- Handshake: hold req_valid during SB -> req_ready low for 3 cycles; the second request is accepted the cycle after rsp_valid. With LSU_MISALIGN_TRAP_EN, LW 9 -> err; without it, LW 9 -> data read from bytes 9..12.

Source files
------------

// File: rtl/lsu_rmw_ctrl.sv
// lsu_rmw_ctrl: load/store control between the EX/MEM register and a
// byte-addressed, 4-byte-wide data memory. Converts RV32 LB/LH/LW/LBU/LHU
// and SB/SH/SW into memory transactions:
//   - loads read one word and sign/zero extend the selected low bytes,
//   - SW writes the word directly,
//   - SB/SH perform a read-modify-write so the untouched bytes survive.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   -> halfword accesses with addr[0]!=0 and word accesses with
//                addr[1:0]!=0 are rejected with rsp_err (no memory strobe)
//   undefined -> alignment is not checked; in-range accesses are performed
//                as-is.
//
// Handshake (valid/ready): a request transfers on the rising edge where
// req_valid && req_ready are both high. req_ready is high only while the
// controller is IDLE, so the pipeline holds its request (and stalls) until
// that edge. Request inputs are sampled only on the transfer edge; outside
// it they are ignored. Completion is a one-cycle rsp_valid pulse with
// rsp_err/rsp_data, which then hold their value until the next pulse.

module lsu_rmw_ctrl #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_data,
  output logic [2:0]        dbg_state
);

  // Controller states. IDLE is the reset state and the only accepting one.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // Request fields captured on the accept edge. The access kind is not
  // stored separately: the state path chosen at accept already encodes it.
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;

  // Upper bytes of the old memory word for the sub-word merge; the low
  // byte is always replaced, so it is never kept.
  logic [31:8] merge_q;

  // Request decode and error detection.
  logic              accept;
  logic              kind_bad;
  logic              f3_legal;
  logic [ADDR_W:0]   end_addr;
  logic              range_bad;
  logic              misalign;
  logic              req_err;

  // Datapath helpers.
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign accept   = req_valid && req_ready;
  assign kind_bad = (req_load == req_store);

  // One extra bit keeps addr+4 from wrapping near the top of the space.
  assign end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(4);
  assign range_bad = (end_addr > (ADDR_W+1)'(MEM_BYTES));

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1:0] gives the access size: 01 = halfword, 10 = word.
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = kind_bad || !f3_legal || range_bad || misalign;

  // Legal funct3 codes differ between loads and stores.
  always_comb begin
    f3_legal = 1'b0;
    if (req_load) begin
      case (req_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_legal = 1'b1;
        default:                      f3_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'd0, 3'd1, 3'd2: f3_legal = 1'b1;
        default:          f3_legal = 1'b0;
      endcase
    end
  end

  // Load result extension from the raw memory word (little-endian: the
  // addressed byte is bits [7:0]).
  always_comb begin
    case (funct3_q)
      3'd0:    load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd4:    load_ext = {24'h000000, mem_rdata[7:0]};
      3'd5:    load_ext = {16'h0000, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Sub-word store merge: funct3_q[0] selects SH, otherwise SB.
  assign merged = funct3_q[0] ? {merge_q[31:16], wdata_q[15:0]}
                              : {merge_q[31:8],  wdata_q[7:0]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection; the access path is decided once, at accept.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_load) begin
            state_next = LOAD;
          end else if (req_funct3 == 3'd2) begin
            state_next = WRITE;
          end else begin
            state_next = RMW_RD;
          end
        end
      end
      LOAD:    state_next = RESP;
      WRITE:   state_next = RESP;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake, memory strobes and write data decoded purely from state, so
  // a reset drops every strobe in the same instant as the state.
  always_comb begin
    req_ready     = 1'b0;
    mem_memRead   = 1'b0;
    mem_memWrite  = 1'b0;
    rsp_valid     = 1'b0;
    mem_writeData = 32'h0;
    case (state)
      IDLE:   req_ready = 1'b1;
      LOAD:   mem_memRead = 1'b1;
      WRITE: begin
        mem_memWrite  = 1'b1;
        mem_writeData = wdata_q;
      end
      RMW_RD: mem_memRead = 1'b1;
      RMW_WR: begin
        mem_memWrite  = 1'b1;
        mem_writeData = merged;
      end
      RESP:   rsp_valid = 1'b1;
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Capture the request on the accept edge; held for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      funct3_q <= 3'd0;
      wdata_q  <= 32'h0;
    end else if (accept) begin
      addr_q   <= req_addr;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
    end
  end

  // Keep the old upper bytes read during the first half of a sub-word store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      merge_q <= 24'h000000;
    end else if (state == RMW_RD) begin
      merge_q <= mem_rdata[31:8];
    end
  end

  // Response registers change only on the edge that enters RESP, so they
  // stay stable from one rsp_valid pulse to the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err  <= 1'b0;
      rsp_data <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && req_err) begin
            rsp_err  <= 1'b1;
            rsp_data <= 32'h0;
          end
        end
        LOAD: begin
          rsp_err  <= 1'b0;
          rsp_data <= load_ext;
        end
        WRITE, RMW_WR: begin
          rsp_err  <= 1'b0;
          rsp_data <= 32'h0;
        end
        default: begin
          rsp_err  <= rsp_err;
          rsp_data <= rsp_data;
        end
      endcase
    end
  end

  assign mem_address = 32'(addr_q);
  assign dbg_state   = state;

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Bench for lsu_rmw_ctrl: a byte-array memory answers the DUT's strobes, a
// reference model derives expected results from the RV32 load/store rules,
// and directed plus randomized scenarios compare the two.
`timescale 1ns/1ps

module tb_lsu_rmw_ctrl;

  localparam int MEM_BYTES = 128;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic [2:0]  dbg_state;

  lsu_rmw_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_load     (req_load),
    .req_store    (req_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_address  (mem_address),
    .mem_writeData(mem_writeData),
    .mem_memRead  (mem_memRead),
    .mem_memWrite (mem_memWrite),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_data     (rsp_data),
    .dbg_state    (dbg_state)
  );

  // memory seen by the DUT, and the model's own copy
  logic [7:0] mem     [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_address <= 32'(MEM_BYTES - 4))
      for (int k = 0; k < 4; k++) mem_rdata[8*k +: 8] = mem[int'(mem_address) + k];
  end

  always @(negedge clk) begin
    if (mem_memWrite && mem_address <= 32'(MEM_BYTES - 4))
      for (int k = 0; k < 4; k++) mem[int'(mem_address) + k] = mem_writeData[8*k +: 8];
  end

  // scoreboard
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  // observations from the driver
  logic        o_err;
  logic [31:0] o_data, o_wdata, o_waddr;
  int          o_lat, o_rd, o_wr;

  // model expectations
  logic        e_err;
  logic [31:0] e_data, e_wword;
  int          e_lat, e_rd, e_wr;

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic set_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      mem[a + k]     = w[8*k +: 8];
      ref_mem[a + k] = w[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[a + k];
    return w;
  endfunction

  // reference model: outcome of one request from the ISA rules
  function automatic void model_req(input logic ld, input logic st, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd);
    int size;
    bit legal;
    longint unsigned last;
    logic [31:0] w;
    int v;
    size = 1 << f3[1:0];
    legal = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    last = longint'(a) + 4;
    e_err = (ld == st) || !legal || (last > MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
    if (!e_err && (a % size) != 0) e_err = 1'b1;
`endif
    e_rd = 0; e_wr = 0; e_data = 32'h0; e_wword = 32'h0;
    if (e_err) begin
      e_lat = 1;
    end else if (ld) begin
      w = ref_word(a);
      e_rd = 1; e_lat = 2;
      if (size == 4) e_data = w;
      else begin
        v = int'(w % (32'd1 << (8*size)));
        if (!f3[2] && v >= (1 << (8*size - 1))) v -= (1 << (8*size));
        e_data = v;
      end
    end else begin
      for (int k = 0; k < size; k++) ref_mem[a + k] = wd[8*k +: 8];
      e_wword = ref_word(a);
      e_wr = 1;
      e_rd = (size < 4) ? 1 : 0;
      e_lat = (size < 4) ? 3 : 2;
    end
  endfunction

  // driver: one request, observes strobes and the response (bounded waits)
  task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    int guard;
    o_rd = 0; o_wr = 0; o_wdata = 32'h0; o_waddr = 32'h0; o_lat = 99;
    o_err = 1'bx; o_data = 32'hx;
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_funct3 = f3; req_addr = a; req_wdata = wd;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_load = 1'($urandom); req_store = 1'($urandom);
    req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 20; c++) begin
      if (mem_memRead) o_rd++;
      if (mem_memWrite) begin
        o_wr++;
        o_wdata = mem_writeData;
        o_waddr = mem_address;
      end
      if (rsp_valid) begin
        o_lat = c; o_err = rsp_err; o_data = rsp_data;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", req_ready); else n_pass++;
    n_checks++; if (mem_memRead !== 1'b0) $display("FAIL rst_memread: got %b expected 0", mem_memRead); else n_pass++;
    n_checks++; if (mem_memWrite !== 1'b0) $display("FAIL rst_memwrite: got %b expected 0", mem_memWrite); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); else n_pass++;
    n_checks++; if (rsp_data !== 32'h0) $display("FAIL rst_rsp_data: got %h expected 0", rsp_data); else n_pass++;
    n_checks++; if (mem_address !== 32'h0) $display("FAIL rst_mem_address: got %h expected 0", mem_address); else n_pass++;
    n_checks++; if (mem_writeData !== 32'h0) $display("FAIL rst_mem_wdata: got %h expected 0", mem_writeData); else n_pass++;
    n_checks++; if (dbg_state !== 3'd0) $display("FAIL rst_state: got %0d expected 0", dbg_state); else n_pass++;
    reset = 1'b1;
    // SB aborted by reset while reading the old word
    set_word(16, 32'hA5A5A5A5);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
    req_funct3 = 3'd0; req_addr = 32'd16; req_wdata = 32'h0000005A;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mem_memRead !== 1'b1) $display("FAIL abort_in_rmw_rd: got %b expected 1", mem_memRead); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (mem_memWrite !== 1'b0) $display("FAIL abort_memwrite: got %b expected 0", mem_memWrite); else n_pass++;
    n_checks++; if (dbg_state !== 3'd0) $display("FAIL abort_state: got %0d expected 0", dbg_state); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL abort_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
    // request held while reset low must be ignored
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
    req_funct3 = 3'd2; req_addr = 32'd16;
    repeat (2) @(negedge clk);
    n_checks++; if (mem_memRead !== 1'b0) $display("FAIL in_reset_ignored: got %b expected 0", mem_memRead); else n_pass++;
    n_checks++; if (ref_word(16) !== {mem[19], mem[18], mem[17], mem[16]})
      $display("FAIL abort_mem_intact: got %h expected %h", {mem[19], mem[18], mem[17], mem[16]}, ref_word(16)); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mem_memRead !== 1'b1) $display("FAIL post_reset_accept: got %b expected 1", mem_memRead); else n_pass++;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL post_reset_rsp: got %b expected 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 32'hA5A5A5A5) $display("FAIL post_reset_data: got %h expected a5a5a5a5", rsp_data); else n_pass++;
  endtask

  task automatic test_sw_lw();
    model_req(1'b0, 1'b1, 3'd2, 32'd8, 32'hDEADBEEF);
    drive_req(1'b0, 1'b1, 3'd2, 32'd8, 32'hDEADBEEF);
    n_checks++; if (o_err !== 1'b0) $display("FAIL sw_err: got %b expected 0", o_err); else n_pass++;
    n_checks++; if (o_lat != 2) $display("FAIL sw_latency: got %0d expected 2", o_lat); else n_pass++;
    n_checks++; if (o_wr != 1 || o_rd != 0) $display("FAIL sw_strobes: got rd=%0d wr=%0d expected rd=0 wr=1", o_rd, o_wr); else n_pass++;
    n_checks++; if (o_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h expected deadbeef", o_wdata); else n_pass++;
    n_checks++; if (o_waddr !== 32'd8) $display("FAIL sw_waddr: got %h expected 8", o_waddr); else n_pass++;
    model_req(1'b1, 1'b0, 3'd2, 32'd8, 32'h0);
    drive_req(1'b1, 1'b0, 3'd2, 32'd8, 32'h0);
    n_checks++; if (o_data !== 32'hDEADBEEF) $display("FAIL lw_data: got %h expected deadbeef", o_data); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL lw_err: got %b expected 0", o_err); else n_pass++;
    n_checks++; if (o_lat != 2 || o_rd != 1) $display("FAIL lw_timing: got lat=%0d rd=%0d expected lat=2 rd=1", o_lat, o_rd); else n_pass++;
  endtask

  task automatic test_sb_rmw();
    set_word(8, 32'h11223344);
    model_req(1'b0, 1'b1, 3'd0, 32'd8, 32'hFFFFFFAB);
    drive_req(1'b0, 1'b1, 3'd0, 32'd8, 32'hFFFFFFAB);
    n_checks++; if (o_rd != 1 || o_wr != 1) $display("FAIL sb_strobes: got rd=%0d wr=%0d expected 1/1", o_rd, o_wr); else n_pass++;
    n_checks++; if (o_wdata !== 32'h112233AB) $display("FAIL sb_merge: got %h expected 112233ab", o_wdata); else n_pass++;
    n_checks++; if (o_lat != 3) $display("FAIL sb_latency: got %0d expected 3", o_lat); else n_pass++;
    n_checks++; if (o_data !== 32'h0 || o_err !== 1'b0) $display("FAIL sb_rsp: got data=%h err=%b expected 0/0", o_data, o_err); else n_pass++;
    model_req(1'b0, 1'b1, 3'd1, 32'd8, 32'h9876CDEF);
    drive_req(1'b0, 1'b1, 3'd1, 32'd8, 32'h9876CDEF);
    n_checks++; if (o_wdata !== 32'h1122CDEF) $display("FAIL sh_merge: got %h expected 1122cdef", o_wdata); else n_pass++;
    model_req(1'b1, 1'b0, 3'd2, 32'd8, 32'h0);
    drive_req(1'b1, 1'b0, 3'd2, 32'd8, 32'h0);
    n_checks++; if (o_data !== 32'h1122CDEF) $display("FAIL rmw_readback: got %h expected 1122cdef", o_data); else n_pass++;
  endtask

  task automatic test_extension();
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] exps [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0};
    set_word(12, 32'h000080F0);
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 1'b0, f3s[i], 32'd12, 32'h0);
      n_checks++; if (o_data !== exps[i]) $display("FAIL ext_f3_%0d: got %h expected %h", f3s[i], o_data, exps[i]); else n_pass++;
    end
  endtask

  task automatic test_boundary();
    logic        lds [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        sts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [5] = '{3'd2, 3'd2, 3'd2, 3'd4, 3'd2};
    logic [31:0] as  [5] = '{32'd124, 32'd125, 32'hFFFFFFFE, 32'd0, 32'd0};
    logic        errs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    set_word(124, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      drive_req(lds[i], sts[i], f3s[i], as[i], 32'h12345678);
      n_checks++; if (o_err !== errs[i]) $display("FAIL bnd_err_%0d: got %b expected %b", i, o_err, errs[i]); else n_pass++;
      n_checks++; if (o_lat != (errs[i] ? 1 : 2)) $display("FAIL bnd_lat_%0d: got %0d expected %0d", i, o_lat, errs[i] ? 1 : 2); else n_pass++;
      if (errs[i]) begin
        n_checks++; if (o_rd + o_wr != 0) $display("FAIL bnd_strobe_%0d: got %0d expected 0", i, o_rd + o_wr); else n_pass++;
        n_checks++; if (o_data !== 32'h0) $display("FAIL bnd_data_%0d: got %h expected 0", i, o_data); else n_pass++;
      end else begin
        n_checks++; if (o_data !== 32'hCAFEF00D) $display("FAIL bnd_data_%0d: got %h expected cafef00d", i, o_data); else n_pass++;
      end
    end
  endtask

  task automatic test_handshake();
    int low;
    int rsp_at;
    @(negedge clk);
    model_req(1'b0, 1'b1, 3'd0, 32'd20, 32'h00000077);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
    req_funct3 = 3'd0; req_addr = 32'd20; req_wdata = 32'h00000077;
    @(negedge clk);
    // second request waits behind the SB with req_valid held
    req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'd20;
    low = 0; rsp_at = 0;
    for (int c = 1; c <= 10; c++) begin
      if (rsp_valid) rsp_at = c;
      if (req_ready) break;
      low++;
      @(negedge clk);
    end
    n_checks++; if (low != 3) $display("FAIL hs_ready_low: got %0d expected 3", low); else n_pass++;
    n_checks++; if (rsp_at != 3) $display("FAIL hs_rsp_cycle: got %0d expected 3", rsp_at); else n_pass++;
    model_req(1'b1, 1'b0, 3'd2, 32'd20, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mem_memRead !== 1'b1) $display("FAIL hs_second_accept: got %b expected 1", mem_memRead); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL hs_pulse_width: got %b expected 0", rsp_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== e_data)
      $display("FAIL hs_second_rsp: got v=%b d=%h expected v=1 d=%h", rsp_valid, rsp_data, e_data); else n_pass++;
  endtask

  task automatic test_misalign();
    set_word(8, 32'h44332211);
    set_word(12, 32'h88776655);
    model_req(1'b1, 1'b0, 3'd2, 32'd9, 32'h0);
    drive_req(1'b1, 1'b0, 3'd2, 32'd9, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (o_err !== 1'b1 || o_rd != 0) $display("FAIL lw9_trap: got err=%b rd=%0d expected 1/0", o_err, o_rd); else n_pass++;
`else
    n_checks++; if (o_err !== 1'b0 || o_data !== 32'h55443322) $display("FAIL lw9_data: got err=%b d=%h expected 0/55443322", o_err, o_data); else n_pass++;
`endif
    n_checks++; if (o_data !== e_data) $display("FAIL lw9_model: got %h expected %h", o_data, e_data); else n_pass++;
  endtask

  task automatic test_random();
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] a, wd, want;
    int r;
    for (int i = 0; i < MEM_BYTES; i += 4) set_word(i, $urandom);
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      ld = (r == 0) || (r >= 2 && r <= 5);
      st = (r == 0) || (r >= 6);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
      wd = $urandom;
      model_req(ld, st, f3, a, wd);
      exp_q.push_back(e_data);
      drive_req(ld, st, f3, a, wd);
      want = exp_q.pop_front();
      n_checks++; if (o_data !== want) $display("FAIL rnd%0d_data: got %h expected %h", n, o_data, want); else n_pass++;
      n_checks++; if (o_err !== e_err) $display("FAIL rnd%0d_err: got %b expected %b", n, o_err, e_err); else n_pass++;
      n_checks++; if (o_lat != e_lat) $display("FAIL rnd%0d_lat: got %0d expected %0d", n, o_lat, e_lat); else n_pass++;
      n_checks++; if (o_rd != e_rd || o_wr != e_wr)
        $display("FAIL rnd%0d_strobes: got rd=%0d wr=%0d expected rd=%0d wr=%0d", n, o_rd, o_wr, e_rd, e_wr); else n_pass++;
      if (e_wr != 0) begin
        n_checks++; if (o_wdata !== e_wword || o_waddr !== a)
          $display("FAIL rnd%0d_write: got %h@%h expected %h@%h", n, o_wdata, o_waddr, e_wword, a); else n_pass++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_extension();
    test_boundary();
    test_handshake();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
